// File: rtl/fp_exception_stage.sv
// Exception-check stage at the tail of the FP adder pipeline: classifies NaN/overflow/underflow,
// packs the IEEE-754-style result and holds it in a valid/ready register slice with sticky flags and counters.
module fp_exception_stage #(
  parameter int EXP_W          = 8,
  parameter int FRAC_W         = 23,
  parameter int CNT_W          = 16,
  parameter int KEEP_ZERO_SIGN = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_s,
  input  logic [EXP_W+1:0]          in_exp,
  input  logic [FRAC_W-1:0]         in_frac,
  input  logic                      in_nan,
  input  logic                      sat_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+FRAC_W:0]     out_result,
  output logic [2:0]                out_exc,
  output logic [2:0]                flags,
  input  logic                      flags_clr,
  output logic [CNT_W-1:0]          cnt_ovf,
  output logic [CNT_W-1:0]          cnt_udf,
  output logic [CNT_W-1:0]          cnt_nan,
  input  logic                      cnt_clr
);

  localparam int RES_W = 1 + EXP_W + FRAC_W;

  localparam logic [EXP_W+1:0]  EMAX_WIDE = {2'b00, {EXP_W{1'b1}}};
  localparam logic [EXP_W-1:0]  EMAX      = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0]  EMAX_M1   = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [FRAC_W-1:0] QNAN_FRAC = {1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic                 out_valid_q, out_valid_d;
  logic [RES_W-1:0]     out_result_q, out_result_d;
  logic [2:0]           out_exc_q, out_exc_d;
  logic [2:0]           flags_q, flags_d;
  // Counter index follows the out_exc bit position: 2 = NaN, 1 = overflow, 0 = underflow.
  logic [2:0][CNT_W-1:0] cnt_q, cnt_d;

  logic                 accept;
  logic                 is_ovf, is_udf;
  logic [RES_W-1:0]     cls_result;
  logic [2:0]           cls_exc;
  logic [2:0]           event_bits;
  logic                 zero_sign;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Exponent is two's complement: negative or zero means below the normal range.
  assign is_udf    = in_exp[EXP_W+1] || (in_exp == '0);
  assign is_ovf    = !in_exp[EXP_W+1] && (in_exp >= EMAX_WIDE);
  assign zero_sign = (KEEP_ZERO_SIGN != 0) ? in_s : 1'b0;

  always_comb begin
    cls_result = {in_s, in_exp[EXP_W-1:0], in_frac};
    cls_exc    = 3'b000;
    if (in_nan) begin
      cls_result = {1'b0, EMAX, QNAN_FRAC};
      cls_exc    = 3'b100;
    end else if (is_ovf) begin
      cls_exc = 3'b010;
      if (sat_mode) begin
        cls_result = {in_s, EMAX_M1, {FRAC_W{1'b1}}};
      end else begin
        cls_result = {in_s, EMAX, {FRAC_W{1'b0}}};
      end
    end else if (is_udf) begin
      cls_exc    = 3'b001;
      cls_result = {zero_sign, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};
    end
  end

  assign event_bits = accept ? cls_exc : 3'b000;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_exc_d    = out_exc_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_result_d = cls_result;
      out_exc_d    = cls_exc;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // A clear and a new event in the same cycle leave only the new event's bit set.
  always_comb begin
    flags_d = (flags_clr ? 3'b000 : flags_q) | event_bits;
  end

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (cnt_clr) begin
        cnt_d[i] = event_bits[i] ? CNT_ONE : '0;
      end else if (event_bits[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_exc_q    <= 3'b000;
      flags_q      <= 3'b000;
      cnt_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_exc_q    <= out_exc_d;
      flags_q      <= flags_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_exc    = out_exc_q;
  assign flags      = flags_q;
  assign cnt_nan    = cnt_q[2];
  assign cnt_ovf    = cnt_q[1];
  assign cnt_udf    = cnt_q[0];

endmodule

// File: tb/tb_fp_exception_stage.sv
// Directed bench for fp_exception_stage: a default instance plus one with KEEP_ZERO_SIGN=1, CNT_W=2.
module tb_fp_exception_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_s, in_nan, sat_mode, out_ready, flags_clr, cnt_clr;
  logic [9:0]  in_exp;
  logic [22:0] in_frac;

  logic        in_ready, out_valid;
  logic [31:0] out_result;
  logic [2:0]  out_exc, flags;
  logic [15:0] cnt_ovf, cnt_udf, cnt_nan;

  logic        k_in_ready, k_out_valid;
  logic [31:0] k_out_result;
  logic [2:0]  k_out_exc, k_flags;
  logic [1:0]  k_cnt_ovf, k_cnt_udf, k_cnt_nan;

  int tests = 0;
  int fails = 0;

  logic [2:0] flags_m;
  int         cnt_m [3];

  always #5 clk = ~clk;

  fp_exception_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_s(in_s), .in_exp(in_exp), .in_frac(in_frac), .in_nan(in_nan),
    .sat_mode(sat_mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_exc(out_exc), .flags(flags),
    .flags_clr(flags_clr), .cnt_ovf(cnt_ovf), .cnt_udf(cnt_udf),
    .cnt_nan(cnt_nan), .cnt_clr(cnt_clr)
  );

  fp_exception_stage #(.EXP_W(8), .FRAC_W(23), .CNT_W(2), .KEEP_ZERO_SIGN(1)) dut_k (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(k_in_ready),
    .in_s(in_s), .in_exp(in_exp), .in_frac(in_frac), .in_nan(in_nan),
    .sat_mode(sat_mode), .out_valid(k_out_valid), .out_ready(out_ready),
    .out_result(k_out_result), .out_exc(k_out_exc), .flags(k_flags),
    .flags_clr(flags_clr), .cnt_ovf(k_cnt_ovf), .cnt_udf(k_cnt_udf),
    .cnt_nan(k_cnt_nan), .cnt_clr(cnt_clr)
  );

  typedef struct {
    logic        s;
    logic [9:0]  e;
    logic [22:0] f;
    logic        nan;
    logic        sat;
    logic [31:0] r;
    logic [31:0] rk;
    logic [2:0]  x;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat_to(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk_state(input string name);
    chk({name, ".flags"}, 64'(flags), 64'(flags_m));
    chk({name, ".cnt_nan"}, 64'(cnt_nan), 64'(sat_to(cnt_m[2], 65535)));
    chk({name, ".cnt_ovf"}, 64'(cnt_ovf), 64'(sat_to(cnt_m[1], 65535)));
    chk({name, ".cnt_udf"}, 64'(cnt_udf), 64'(sat_to(cnt_m[0], 65535)));
    chk({name, ".k_cnt_ovf"}, 64'(k_cnt_ovf), 64'(sat_to(cnt_m[1], 3)));
  endtask

  task automatic model_update(input logic fclr, input logic cclr, input logic [2:0] x);
    if (fclr) flags_m = 3'b000;
    flags_m = flags_m | x;
    for (int k = 0; k < 3; k++) begin
      if (cclr) cnt_m[k] = x[k] ? 1 : 0;
      else      cnt_m[k] = cnt_m[k] + (x[k] ? 1 : 0);
    end
  endtask

  // One accepted transaction with out_ready high; result checked one edge later.
  task automatic send(input string name, input logic s, input logic [9:0] e, input logic [22:0] f,
                      input logic nan, input logic sat, input logic fclr,
                      input logic [31:0] er, input logic [31:0] ek, input logic [2:0] ex);
    in_s = s; in_exp = e; in_frac = f; in_nan = nan; sat_mode = sat;
    in_valid = 1'b1; out_ready = 1'b1; flags_clr = fclr; cnt_clr = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; flags_clr = 1'b0;
    model_update(fclr, 1'b0, ex);
    $display("[TB] %s: exp_in=%0h res=%08h exc=%b flags=%b", name, e, out_result, out_exc, flags);
    chk({name, ".valid"}, 64'(out_valid), 64'd1);
    chk({name, ".result"}, 64'(out_result), 64'(er));
    chk({name, ".exc"}, 64'(out_exc), 64'(ex));
    chk({name, ".k_result"}, 64'(k_out_result), 64'(ek));
    chk_state(name);
  endtask

  task automatic idle(input string name, input logic fclr, input logic cclr);
    in_valid = 1'b0; out_ready = 1'b1; flags_clr = fclr; cnt_clr = cclr;
    @(posedge clk); #1;
    flags_clr = 1'b0; cnt_clr = 1'b0;
    model_update(fclr, cclr, 3'b000);
    $display("[TB] %s: idle flags=%b cnt_ovf=%0d", name, flags, cnt_ovf);
    chk({name, ".valid"}, 64'(out_valid), 64'd0);
    chk_state(name);
  endtask

  vec_t        vt [11];
  logic [31:0] bp_exp [4];
  int          idx, rcv;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_s = 1'b0; in_exp = '0; in_frac = '0;
    in_nan = 1'b0; sat_mode = 1'b0; out_ready = 1'b1; flags_clr = 1'b0; cnt_clr = 1'b0;
    flags_m = 3'b000;
    for (int k = 0; k < 3; k++) cnt_m[k] = 0;

    vt[0]  = '{1'b1, 10'd300, 23'h0,      1'b0, 1'b0, 32'hFF80_0000, 32'hFF80_0000, 3'b010};
    vt[1]  = '{1'b1, 10'd300, 23'h0,      1'b0, 1'b1, 32'hFF7F_FFFF, 32'hFF7F_FFFF, 3'b010};
    vt[2]  = '{1'b0, 10'd255, 23'h0,      1'b0, 1'b0, 32'h7F80_0000, 32'h7F80_0000, 3'b010};
    vt[3]  = '{1'b0, 10'd254, 23'h12345,  1'b0, 1'b0, 32'h7F01_2345, 32'h7F01_2345, 3'b000};
    vt[4]  = '{1'b1, 10'd0,   23'h1,      1'b0, 1'b0, 32'h0000_0000, 32'h8000_0000, 3'b001};
    vt[5]  = '{1'b1, 10'h3FB, 23'h7,      1'b0, 1'b0, 32'h0000_0000, 32'h8000_0000, 3'b001};
    vt[6]  = '{1'b1, 10'd255, 23'h55,     1'b1, 1'b0, 32'h7FC0_0000, 32'h7FC0_0000, 3'b100};
    vt[7]  = '{1'b1, 10'd1,   23'h7FFFFF, 1'b0, 1'b0, 32'h80FF_FFFF, 32'h80FF_FFFF, 3'b000};
    vt[8]  = '{1'b0, 10'h200, 23'h1,      1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 3'b001};
    vt[9]  = '{1'b0, 10'h1FF, 23'h1,      1'b0, 1'b0, 32'h7F80_0000, 32'h7F80_0000, 3'b010};
    vt[10] = '{1'b0, 10'd127, 23'h0,      1'b0, 1'b0, 32'h3F80_0000, 32'h3F80_0000, 3'b000};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset.valid", 64'(out_valid), 64'd0);
    chk("reset.result", 64'(out_result), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("reset.in_ready", 64'(in_ready), 64'd1);
    chk("reset.exc", 64'(out_exc), 64'd0);
    chk_state("reset");

    // Table vectors streamed back to back
    for (int i = 0; i < 11; i++) begin
      send($sformatf("vec%0d", i), vt[i].s, vt[i].e, vt[i].f, vt[i].nan, vt[i].sat, 1'b0,
           vt[i].r, vt[i].rk, vt[i].x);
    end
    idle("drain", 1'b0, 1'b0);

    // Flag clear colliding with an underflow accept
    idle("fclr", 1'b1, 1'b0);
    send("f_ovf", 1'b0, 10'd300, 23'h0, 1'b0, 1'b0, 1'b0, 32'h7F80_0000, 32'h7F80_0000, 3'b010);
    send("f_nan", 1'b0, 10'd5,   23'h0, 1'b1, 1'b0, 1'b0, 32'h7FC0_0000, 32'h7FC0_0000, 3'b100);
    chk("f.flags110", 64'(flags), 64'd6);
    send("f_udf_clr", 1'b0, 10'd0, 23'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 3'b001);

    // Counter clear then saturation of the 2-bit counter
    idle("cclr", 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      send($sformatf("sat%0d", i), 1'b0, 10'd300, 23'h0, 1'b0, 1'b1, 1'b0,
           32'h7F7F_FFFF, 32'h7F7F_FFFF, 3'b010);
    end
    chk("sat.k_cnt_ovf", 64'(k_cnt_ovf), 64'd3);
    idle("sat_drain", 1'b0, 1'b0);

    // Backpressure: 4 normals, out_ready low for 3 cycles mid-stream
    for (int i = 0; i < 4; i++) bp_exp[i] = {1'b0, 8'(100 + i), 23'(i)};
    idx = 0; rcv = 0;
    for (int c = 0; c < 40 && rcv < 4; c++) begin
      out_ready = !(c >= 2 && c < 5);
      in_valid  = (idx < 4);
      in_s = 1'b0; in_nan = 1'b0; sat_mode = 1'b0;
      in_exp = 10'(100 + idx); in_frac = 23'(idx);
      @(negedge clk);
      if (out_valid && !out_ready) begin
        chk($sformatf("bp.stall_ready_c%0d", c), 64'(in_ready), 64'd0);
        chk($sformatf("bp.stall_hold_c%0d", c), 64'(out_result), 64'(bp_exp[rcv]));
      end
      if (out_valid && out_ready) begin
        $display("[TB] bp: deliver %0d res=%08h", rcv, out_result);
        chk($sformatf("bp.deliver%0d", rcv), 64'(out_result), 64'(bp_exp[rcv]));
        rcv++;
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp.count", 64'(rcv), 64'd4);
    idle("bp_drain", 1'b0, 1'b0);

    // Asynchronous reset while a result is held under backpressure
    in_s = 1'b0; in_exp = 10'd127; in_frac = 23'h0; in_nan = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst.held_valid", 64'(out_valid), 64'd1);
    chk("rst.held_in_ready", 64'(in_ready), 64'd0);
    chk("rst.held_result", 64'(out_result), 64'h3F80_0000);
    #1 rst_n = 1'b0;
    #1;
    $display("[TB] rst: async assert valid=%b flags=%b cnt_ovf=%0d", out_valid, flags, cnt_ovf);
    flags_m = 3'b000;
    for (int k = 0; k < 3; k++) cnt_m[k] = 0;
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.result", 64'(out_result), 64'd0);
    chk_state("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    send("post_rst", 1'b1, 10'd128, 23'h400000, 1'b0, 1'b0, 1'b0,
         32'hC040_0000, 32'hC040_0000, 3'b000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
